pokey_key_scanner: RTL

- Keyboard scan controller for the POKEY core.
- Sequences the 6-bit keyboard matrix scan on key_scan_L and samples the kr1_L / kr2_L return lines each scan slot.
- Debounces key presses over two consecutive scan frames and latches the accepted key into a KBCODE register with shift/ctrl modifiers.
- Flags key-down status for SKSTAT and emits a one-cycle keyboard interrupt request to the IRQ block.

---
 rtl/pokey_key_scanner_pkg.sv | 22 ++
 rtl/pokey_scan_timer.sv | 38 +++
 rtl/pokey_key_scanner.sv | 104 ++++++++++
 3 files changed

// File: rtl/pokey_key_scanner_pkg.sv
// Shared POKEY constants: keyboard FSM encoding, KBCODE bit layout and scan timing.
package pokey_key_scanner_pkg;

    localparam int SCAN_DIV_DEF = 114;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    localparam int CTRL_BIT  = 7;
    localparam int SHIFT_BIT = 6;

    function automatic logic [7:0] pack_kbcode(input logic ctrl, input logic shift,
                                               input logic [5:0] key);
        logic [7:0] code;
        code            = {2'b00, key};
        code[CTRL_BIT]  = ctrl;
        code[SHIFT_BIT] = shift;
        return code;
    endfunction

endpackage

// File: rtl/pokey_scan_timer.sv
// Slot divider and scan index counter; shared by keyboard and pot scanning.
module pokey_scan_timer
    import pokey_key_scanner_pkg::*;
#(
    parameter int DIV   = SCAN_DIV_DEF,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strobe,
    output logic [IDX_W-1:0] idx
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Disable wins over the strobe so nothing downstream sees a sample while stopped.
    assign strobe = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (strobe) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pokey_key_scanner.sv
// Keyboard matrix scanner: debounces over two frames, latches KBCODE, raises a key IRQ.
module pokey_key_scanner
    import pokey_key_scanner_pkg::*;
#(
    parameter int         SCAN_DIV  = SCAN_DIV_DEF,
    parameter logic [5:0] SHIFT_IDX = 6'h10,
    parameter logic [5:0] CTRL_IDX  = 6'h20
) (
    input  logic       o2,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       kr1_L,
    input  logic       kr2_L,
    output logic [5:0] key_scan_L,
    output logic [7:0] kbcode,
    output logic       keydown,
    output logic       shift_held,
    output logic       kbd_irq
);

    logic [1:0] kr1_sync, kr2_sync;
    logic       kr1_s, kr2_s;
    logic       strobe;
    logic [5:0] idx;
    logic [5:0] cand;
    logic [1:0] state;
    logic       ctrl_lat;

    always_ff @(posedge o2 or posedge rst) begin
        if (rst) begin
            kr1_sync <= 2'b11;
            kr2_sync <= 2'b11;
        end else begin
            kr1_sync <= {kr1_sync[0], kr1_L};
            kr2_sync <= {kr2_sync[0], kr2_L};
        end
    end

    assign kr1_s = kr1_sync[1];
    assign kr2_s = kr2_sync[1];

    pokey_scan_timer #(.DIV(SCAN_DIV), .IDX_W(6)) u_timer (
        .clk    (o2),
        .rst    (rst),
        .en     (scan_en),
        .strobe (strobe),
        .idx    (idx)
    );

    assign key_scan_L = ~idx;

    always_ff @(posedge o2 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cand       <= '0;
            kbcode     <= '0;
            keydown    <= 1'b0;
            shift_held <= 1'b0;
            ctrl_lat   <= 1'b0;
            kbd_irq    <= 1'b0;
        end else if (!scan_en) begin
            // kbcode and ctrl latch are deliberately retained across a scan stop.
            state      <= ST_IDLE;
            keydown    <= 1'b0;
            shift_held <= 1'b0;
            kbd_irq    <= 1'b0;
        end else begin
            kbd_irq <= 1'b0;
            if (strobe) begin
                if (idx == SHIFT_IDX) shift_held <= ~kr2_s;
                if (idx == CTRL_IDX)  ctrl_lat   <= ~kr2_s;
                case (state)
                    ST_IDLE: begin
                        if (!kr1_s) begin
                            cand  <= idx;
                            state <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (idx == cand) begin
                            if (!kr1_s) begin
                                state   <= ST_PRESSED;
                                kbcode  <= pack_kbcode(ctrl_lat, shift_held, cand);
                                keydown <= 1'b1;
                                kbd_irq <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_PRESSED: begin
                        // Other keys are invisible until the held one is seen released.
                        if (idx == cand && kr1_s) begin
                            state   <= ST_IDLE;
                            keydown <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
